// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM states, response-error codes, select-field width helper.
// Pure declarations; no timing or backpressure of its own.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SLV     = 2'd1;
    localparam logic [1:0] ERR_DECODE  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A single slave still needs one select bit so the field is never zero-width.
    function automatic int sel_w(input int num_slv);
        return (num_slv <= 2) ? 1 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Command/response port plus APB bus bundle; master = bridge view, slave = controller/slave-bank view.
// Wires only; cmd_valid/cmd_ready carry the request backpressure.
interface apb_master_nslv_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [DATA_W-1:0]           cmd_wdata;
    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_err;
    logic [ADDR_W-1:0]           PADDR;
    logic [NUM_SLV-1:0]          PSEL;
    logic                        PENABLE;
    logic                        PWRITE;
    logic [DATA_W-1:0]           PWDATA;
    logic [NUM_SLV*DATA_W-1:0]   PRDATA;
    logic [NUM_SLV-1:0]          PREADY;
    logic [NUM_SLV-1:0]          PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_addr_decoder.sv
// Address to one-hot slave select; flags select-field values with no slave behind them.
// Purely combinational, no backpressure.
module apb_addr_decoder import apb_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    localparam int SEL_W  = sel_w(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_decode_err
);
    logic w_unused_addr;

    // Only the select field matters here; the rest of the address goes to PADDR.
    assign w_unused_addr = ^i_addr;
    assign o_idx         = i_addr[SEL_LSB +: SEL_W];
    assign o_decode_err  = (int'(o_idx) >= NUM_SLV);

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            o_sel[i] = !o_decode_err && (o_idx == SEL_W'(i));
        end
    end
endmodule

// File: rtl/apb_master_nslv.sv
// APB master bridge to NUM_SLV slaves; APB_TIMEOUT_EN adds an ACCESS wait-cycle abort.
// Response 3 cycles after accept plus wait states; cmd_ready only in IDLE, so one command in flight.
module apb_master_nslv import apb_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_master_nslv_if.master bus
);
    localparam int SEL_W = sel_w(NUM_SLV);

    if (NUM_SLV < 1 || NUM_SLV > 16 || !(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || TIMEOUT < 1) begin : g_bad_param
        $error("apb_master_nslv: unsupported parameter set");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [SEL_W-1:0]    r_idx;
    logic [NUM_SLV-1:0]  r_sel;
    logic                r_rsp_vld;
    logic [1:0]          r_rsp_code;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic [NUM_SLV-1:0]  w_dec_sel;
    logic [SEL_W-1:0]    w_dec_idx;
    logic                w_dec_err;
    logic                w_accept;
    logic                w_slv_rdy;
    logic                w_slv_err;
    logic [DATA_W-1:0]   w_slv_rdata;
    logic                w_timeout;
    logic                w_rsp_vld_nxt;
    logic [1:0]          w_rsp_code_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;

    apb_addr_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB)
    ) u_dec (
        .i_addr       (bus.cmd_addr),
        .o_sel        (w_dec_sel),
        .o_idx        (w_dec_idx),
        .o_decode_err (w_dec_err)
    );

    assign w_accept    = (r_state == IDLE) && bus.cmd_valid;
    // Only the addressed slave's return signals are ever looked at.
    assign w_slv_rdy   = bus.PREADY[r_idx];
    assign w_slv_err   = bus.PSLVERR[r_idx];
    assign w_slv_rdata = bus.PRDATA[int'(r_idx)*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == ACCESS) && !w_slv_rdy && (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Sits at zero outside ACCESS, so it is already clear on ACCESS entry.
    always_ff @(posedge PCLK) begin
        if (PRESET || r_state != ACCESS) begin
            r_to_cnt <= '0;
        end else if (!w_slv_rdy) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_vld_nxt   = 1'b0;
        w_rsp_code_nxt  = ERR_NONE;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (w_dec_err) begin
                        w_rsp_vld_nxt  = 1'b1;
                        w_rsp_code_nxt = ERR_DECODE;
                    end else begin
                        w_state_nxt = SETUP;
                    end
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                if (w_slv_rdy) begin
                    w_state_nxt     = IDLE;
                    w_rsp_vld_nxt   = 1'b1;
                    w_rsp_code_nxt  = w_slv_err ? ERR_SLV : ERR_NONE;
                    w_rsp_rdata_nxt = (!r_write && !w_slv_err) ? w_slv_rdata : '0;
                end else if (w_timeout) begin
                    w_state_nxt    = IDLE;
                    w_rsp_vld_nxt  = 1'b1;
                    w_rsp_code_nxt = ERR_TIMEOUT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_rsp_vld   <= 1'b0;
            r_rsp_code  <= ERR_NONE;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_vld   <= w_rsp_vld_nxt;
            r_rsp_code  <= w_rsp_code_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_sel   <= '0;
        end else if (w_accept) begin
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_write <= bus.cmd_write;
            r_idx   <= w_dec_idx;
            r_sel   <= w_dec_sel;
        end
    end

    // cmd_ready is gated by reset so every output reads 0 while PRESET is held.
    assign bus.cmd_ready = (r_state == IDLE) && !PRESET;
    assign bus.PADDR     = r_addr;
    assign bus.PWRITE    = r_write;
    assign bus.PWDATA    = r_wdata;
    assign bus.PSEL      = (r_state == SETUP || r_state == ACCESS) ? r_sel : '0;
    assign bus.PENABLE   = (r_state == ACCESS);
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_err   = (r_rsp_code != ERR_NONE);
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench: a 4-slave and a 3-slave bridge driven by directed and random transfers against an address/latency model.
module tb_apb_master_nslv;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NA = 4;
    localparam int NB = 3;
    localparam int SL = 12;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_nslv_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NA)) ifa();
    apb_master_nslv_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NB)) ifb();

    apb_master_nslv #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NA), .SEL_LSB(SL), .TIMEOUT(TO)) dut_a (
        .PCLK(clk), .PRESET(rst), .bus(ifa));
    apb_master_nslv #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NB), .SEL_LSB(SL), .TIMEOUT(TO)) dut_b (
        .PCLK(clk), .PRESET(rst), .bus(ifb));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_slaves_a();
        ifa.PREADY  = 4'($urandom);
        ifa.PSLVERR = 4'($urandom);
        for (int i = 0; i < NA; i++) ifa.PRDATA[i*DW +: DW] = $urandom;
    endtask

    // One transfer on dut_a, stepped cycle by cycle; expectations come from the address arithmetic.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input bit serr, input string tag);
        int          idx;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rd;
        idx     = int'((addr >> SL) & 32'h3);
        exp_sel = 4'b0001 << idx;
        exp_rd  = (wr || serr) ? 32'h0 : rdata;

        ifa.cmd_valid = 1'b1;
        ifa.cmd_write = wr;
        ifa.cmd_addr  = addr;
        ifa.cmd_wdata = wdata;
        rand_slaves_a();
        chk({tag, ".ready"}, ifa.cmd_ready, 1'b1);

        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        ifa.cmd_addr  = $urandom;
        ifa.cmd_wdata = $urandom;
        ifa.cmd_write = ~wr;
        chk({tag, ".setup"},
            {ifa.PSEL, ifa.PENABLE, ifa.PADDR, ifa.PWRITE, ifa.PWDATA, ifa.rsp_valid, ifa.cmd_ready},
            {exp_sel, 1'b0, addr, wr, wdata, 1'b0, 1'b0});
        rand_slaves_a();
        ifa.PREADY[idx] = 1'b0;

        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            chk({tag, ".access"},
                {ifa.PSEL, ifa.PENABLE, ifa.PADDR, ifa.PWRITE, ifa.PWDATA, ifa.rsp_valid, ifa.cmd_ready},
                {exp_sel, 1'b1, addr, wr, wdata, 1'b0, 1'b0});
            rand_slaves_a();
            ifa.PREADY[idx] = (w == waits);
            if (w == waits) begin
                ifa.PRDATA[idx*DW +: DW] = rdata;
                ifa.PSLVERR[idx]         = serr;
            end
        end

        @(negedge clk);
        chk({tag, ".rsp"},
            {ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata, ifa.PSEL, ifa.PENABLE, ifa.cmd_ready},
            {1'b1, serr, exp_rd, 4'b0000, 1'b0, 1'b1});
    endtask

    initial begin
        int          n_seen;
        bit          wr;
        bit          serr;
        int          waits;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;

        ifa.cmd_valid = 1'b0; ifa.cmd_write = 1'b0; ifa.cmd_addr = '0; ifa.cmd_wdata = '0;
        ifa.PRDATA = '0; ifa.PREADY = '0; ifa.PSLVERR = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_write = 1'b0; ifb.cmd_addr = '0; ifb.cmd_wdata = '0;
        ifb.PRDATA = '0; ifb.PREADY = '1; ifb.PSLVERR = '0;

        // Reset state: every output zero while reset is held.
        repeat (3) @(negedge clk);
        chk("reset_a",
            {ifa.cmd_ready, ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata, ifa.PADDR, ifa.PSEL,
             ifa.PENABLE, ifa.PWRITE, ifa.PWDATA}, '0);
        chk("reset_b",
            {ifb.cmd_ready, ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata, ifb.PADDR, ifb.PSEL,
             ifb.PENABLE, ifb.PWRITE, ifb.PWDATA}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write to slave 2.
        do_xfer(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "t1_write");
        @(negedge clk);
        chk("t1_idle_hold",
            {ifa.PADDR, ifa.PWRITE, ifa.PWDATA, ifa.PSEL, ifa.PENABLE, ifa.rsp_valid},
            {32'h0000_2010, 1'b1, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b0});

        // Five wait states on slave 3, then a back-to-back PSLVERR read on slave 1.
        do_xfer(1'b0, 32'h0000_3004, 32'h0BAD_F00D, 5, 32'h1234_5678, 1'b0, "t2_wait_read");
        do_xfer(1'b0, 32'h0000_1008, 32'h0, 1, 32'hFFFF_FFFF, 1'b1, "t3_slverr");
        @(negedge clk);

        // Decode error on the 3-slave bridge: field value 3 has no slave.
        ifb.cmd_valid = 1'b1; ifb.cmd_write = 1'b0; ifb.cmd_addr = 32'h0000_3000;
        chk("t4_ready", ifb.cmd_ready, 1'b1);
        @(negedge clk);
        ifb.cmd_valid = 1'b0;
        chk("t4_decode_rsp", {ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata, ifb.PSEL, ifb.PENABLE, ifb.cmd_ready},
            {1'b1, 1'b1, 32'h0, 3'b000, 1'b0, 1'b1});
        ifb.cmd_valid = 1'b1; ifb.cmd_write = 1'b1; ifb.cmd_addr = 32'h0000_2000; ifb.cmd_wdata = 32'h5A5A_0001;
        @(negedge clk);
        ifb.cmd_valid = 1'b0;
        chk("t4b_setup", {ifb.PSEL, ifb.PENABLE, ifb.rsp_valid}, {3'b100, 1'b0, 1'b0});
        @(negedge clk);
        chk("t4b_access", {ifb.PSEL, ifb.PENABLE, ifb.PWDATA}, {3'b100, 1'b1, 32'h5A5A_0001});
        @(negedge clk);
        chk("t4b_rsp", {ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata, ifb.PSEL}, {1'b1, 1'b0, 32'h0, 3'b000});

        // Reset during ACCESS aborts without a response.
        ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b0; ifa.cmd_addr = 32'h0000_0040; ifa.PREADY = '0;
        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_in_access", {ifa.PSEL, ifa.PENABLE}, {4'b0001, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        chk("t5_abort", {ifa.PSEL, ifa.PENABLE, ifa.rsp_valid}, '0);
        rst = 1'b0;
        ifa.PREADY = '1;
        @(negedge clk);
        chk("t5_no_rsp", {ifa.PSEL, ifa.PENABLE, ifa.rsp_valid, ifa.cmd_ready}, {4'b0000, 1'b0, 1'b0, 1'b1});
        do_xfer(1'b0, 32'h0000_0044, 32'h0, 0, 32'hCAFE_0005, 1'b0, "t5_after");

        // Random transfers, occasionally with an idle gap.
        for (int k = 0; k < 40; k++) begin
            wr    = ($urandom_range(0, 1) == 1);
            serr  = ($urandom_range(0, 3) == 0);
            waits = int'($urandom_range(0, 3));
            addr  = $urandom;
            wd    = $urandom;
            rd    = $urandom;
            do_xfer(wr, addr, wd, waits, rd, serr, "rand");
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk("rand_gap", {ifa.rsp_valid, ifa.PSEL, ifa.PENABLE, ifa.PADDR},
                    {1'b0, 4'b0000, 1'b0, addr});
            end
        end

        // Slave 1 never ready; the other slaves claim ready to show they are ignored.
        ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b0; ifa.cmd_addr = 32'h0000_1100;
        ifa.PREADY = 4'b1101; ifa.PSLVERR = '0; ifa.PRDATA[1*DW +: DW] = 32'h7777_1111;
        n_seen = -1;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            ifa.cmd_valid = 1'b0;
            if (ifa.rsp_valid) begin
                n_seen = n;
                break;
            end
        end
`ifdef APB_TIMEOUT_EN
        chk("t6_timeout_lat", n_seen, 18);
        chk("t6_timeout_rsp", {ifa.rsp_err, ifa.rsp_rdata, ifa.PSEL, ifa.PENABLE}, {1'b1, 32'h0, 4'b0000, 1'b0});
`else
        chk("t6_no_rsp", n_seen, -1);
        chk("t6_still_access", {ifa.PSEL, ifa.PENABLE, ifa.PADDR}, {4'b0010, 1'b1, 32'h0000_1100});
        ifa.PREADY = 4'b0010;
        @(negedge clk);
        chk("t6_release", {ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata}, {1'b1, 1'b0, 32'h7777_1111});
`endif
        @(negedge clk);
        chk("final_idle", {ifa.rsp_valid, ifa.PSEL, ifa.cmd_ready}, {1'b0, 4'b0000, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
